// File: rtl/fft_ring_stop.sv
// fft_ring_stop: ring stop that ejects local traffic, forwards transit MDEST words and injects from a FIFO.
// Define FFT_RING_FAIR_INJ_EN to bound injection starvation to MAX_WAIT lost arbitrations.
module fft_ring_stop #(
    parameter int unsigned NODE_ID        = 0,
    parameter int unsigned INJ_FIFO_DEPTH = 4,
    parameter int unsigned MAX_WAIT       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ring_in_valid,
    input  logic [64:0] ring_in_msg,
    output logic        ring_in_ready,
    output logic        ring_out_valid,
    output logic [64:0] ring_out_msg,
    input  logic        ring_out_ready,
    input  logic        inj_valid,
    input  logic [31:0] inj_fft_pt,
    input  logic        inj_msg_type,
    output logic        inj_ready,
    output logic        ej_valid,
    output logic [64:0] ej_msg,
    input  logic        ej_ready
);
    localparam int AW = $clog2(INJ_FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic          ring_out_valid_q, ring_out_valid_d;
    logic [64:0]   ring_out_msg_q, ring_out_msg_d;
    logic          ej_valid_q, ej_valid_d;
    logic [64:0]   ej_msg_q, ej_msg_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [64:0]   mem_q [INJ_FIFO_DEPTH];
    logic          out_free, ej_free, force_inj, ring_fire, own, fwd, ej, inj_fire;
    logic          fifo_empty, pop, pop_mem, wr;
    logic [64:0]   inj_word, head_word;

    assign out_free      = !ring_out_valid_q | ring_out_ready;
    assign ej_free       = !ej_valid_q | ej_ready;
    assign ring_in_ready = out_free & ej_free & !force_inj;
    assign fifo_empty    = cnt_q == '0;
    assign inj_ready     = cnt_q != CW'(INJ_FIFO_DEPTH);

    always_comb begin
        ring_fire = ring_in_valid & ring_in_ready;
        own       = ring_in_msg[64:33] == 32'(NODE_ID);
        fwd       = ring_fire & ring_in_msg[0] & !own;
        ej        = ring_fire & (!ring_in_msg[0] | !own);
        inj_fire  = inj_valid & inj_ready;
        inj_word  = {32'(NODE_ID), inj_fft_pt, inj_msg_type};
        // An empty FIFO lets a same-cycle inject bypass straight into the ring slot.
        head_word = fifo_empty ? inj_word : mem_q[rd_ptr_q];
        pop       = out_free & !fwd & (!fifo_empty | inj_fire);
        pop_mem   = pop & !fifo_empty;
        wr        = inj_fire & !(fifo_empty & pop);
        ring_out_valid_d = out_free ? (fwd | pop) : 1'b1;
        ring_out_msg_d   = fwd ? ring_in_msg : pop ? head_word : ring_out_msg_q;
        ej_valid_d       = ej | (ej_valid_q & !ej_ready);
        ej_msg_d         = ej ? ring_in_msg : ej_msg_q;
        wr_ptr_d         = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d         = pop_mem ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d            = cnt_q + CW'(wr) - CW'(pop_mem);
    end

`ifdef FFT_RING_FAIR_INJ_EN
    localparam int SW = $clog2(MAX_WAIT + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign force_inj = starve_q == SW'(MAX_WAIT);

    always_comb
        starve_d = pop ? '0 : (!fifo_empty & out_free & fwd) ? starve_q + SW'(1) : starve_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
`else
    assign force_inj = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_out_valid_q <= 1'b0;
            ring_out_msg_q   <= '0;
            ej_valid_q       <= 1'b0;
            ej_msg_q         <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            cnt_q            <= '0;
        end else begin
            ring_out_valid_q <= ring_out_valid_d;
            ring_out_msg_q   <= ring_out_msg_d;
            ej_valid_q       <= ej_valid_d;
            ej_msg_q         <= ej_msg_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            cnt_q            <= cnt_d;
        end
    end

    always_ff @(posedge clk)
        if (wr) mem_q[wr_ptr_q] <= inj_word;

    assign ring_out_valid = ring_out_valid_q;
    assign ring_out_msg   = ring_out_msg_q;
    assign ej_valid       = ej_valid_q;
    assign ej_msg         = ej_msg_q;
endmodule

// File: doc/fft_ring_stop.md
Name: fft_ring_stop

Overview:
- Per-node ring stop for the FFT ring network.
- Accepts ts_fft_ring_msg words (fft_ring_pkg) from the upstream ring link, and ejects those addressed to the local node.
- Forwards the remainder to the downstream link.
- Injects locally generated messages, stamped with this node's ID, into free ring slots through a small FIFO. One instance per ring node, between neighbouring links and the local FFT engine.

Parameters:
- NODE_ID, 0, this node's ID; written into src_node_id of every injected message.
- INJ_FIFO_DEPTH, 4, injection FIFO entries; power of two, minimum 2.
- MAX_WAIT, 8, blocked-injection cycles before a forced slot; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ring_in_valid  in  1  upstream message valid
- ring_in_msg  in  65  upstream ts_fft_ring_msg: [64:33] src_node_id, [32:1] fft_pt, [0] msg_type (0=ODST, 1=MDEST)
- ring_in_ready  out  1  upstream accept
- ring_out_valid  out  1  downstream message valid
- ring_out_msg  out  65  downstream ts_fft_ring_msg
- ring_out_ready  in  1  downstream accept
- inj_valid  in  1  local inject request
- inj_fft_pt  in  32  local FFT point
- inj_msg_type  in  1  local message type
- inj_ready  out  1  injection FIFO not full
- ej_valid  out  1  ejected message valid
- ej_msg  out  65  ejected ts_fft_ring_msg
- ej_ready  in  1  local consumer accept

Behaviour:
- Reset (async, rst_n=0):
  - ring_out_valid=0, ej_valid=0, ring_out_msg=0, ej_msg=0.
  - FIFO empty, so inj_ready=1.
  - ring_in_ready=1.
  - Starvation counter=0.
- Reset mid-operation discards all in-flight and queued messages. Outputs reach reset values immediately and without waiting for a clock.
- Handshakes: all interfaces are valid/ready.
  - A transfer fires on the clk edge where valid&ready=1.
  - A valid output holds its message stable until it is accepted.
- Output slots: ring_out and ej are single registers.
  - out_free = !ring_out_valid | ring_out_ready.
  - ej_free = !ej_valid | ej_ready.
- ring_in_ready = out_free & ej_free (content-independent).
- Classification of an accepted ring_in message:
  - ODST: eject only, no forward. One-hop delivery, consumed by the downstream neighbour.
  - MDEST with src_node_id != NODE_ID: eject a copy and forward it.
  - MDEST with src_node_id == NODE_ID: drop; the circulation is complete. Neither eject nor forward.
- Ring output arbitration, per cycle, when out_free:
  1. Ring forward has priority: if the accepted ring_in message forwards, it loads ring_out.
  2. Otherwise, including the same cycle a ring message is ejected or dropped, the FIFO head loads ring_out if the FIFO is non-empty.
  3. Otherwise ring_out_valid clears once the current message has been accepted.
- Injected message = {NODE_ID[31:0], inj_fft_pt, inj_msg_type}, formed at FIFO write.
- Latency:
  - ring_in fire at edge N gives ring_out_valid / ej_valid at N+1.
  - Inject fire at edge N on an idle ring gives ring_out_valid at N+1 (first-word path).
  - No combinational path from ring_in_valid to ring_out_valid.
- FIFO:
  - inj_ready = !full.
  - A simultaneous push and pop when full is not allowed, because inj_ready=0.
  - A simultaneous push and pop when empty with out_free and no forward loads the new word directly.
  - Pointers wrap modulo INJ_FIFO_DEPTH; occupancy counter is clog2(DEPTH)+1 bits.
- Pre-existing ring traffic is never dropped or reordered. Injected messages leave in FIFO order.

Optional Feature:
- Macro FFT_RING_FAIR_INJ_EN.
- Defined:
  - A counter increments each cycle the FIFO is non-empty, out_free=1, and the head loses to a ring forward.
  - The counter clears on any FIFO pop.
  - When the count reaches MAX_WAIT, the next cycle forces ring_in_ready=0 and pops the FIFO head into ring_out.
  - The counter then clears.
- Undefined: strict ring priority; the counter logic is absent; an injection can starve indefinitely.

Test Plan:
- Reset check: rst_n low mid-traffic -> all valids 0, inj_ready=1, ring_in_ready=1 asynchronously. After release, the FIFO is empty and no stale message appears.
- ODST eject: NODE_ID=2, ring_in {src=1, pt=0x10, ODST} with ej_ready=1 -> ej_valid next cycle, ej_msg equal to the input, ring_out_valid stays 0.
- MDEST: {src=1, pt=0x20, MDEST} -> eject and forward of identical words next cycle. Then {src=2, pt=0x30, MDEST} -> neither ej_valid nor ring_out_valid.
- Injection into a consumed slot: FIFO holds pt=0x40 and ring_in carries an ODST -> that same cycle's edge loads ring_out with {src=2, pt=0x40} alongside the eject.
- Backpressure: ring_out_ready=0 for 5 cycles with traffic pending -> ring_in_ready=0, ring_out_msg stable. Push 5 injects with DEPTH=4 -> inj_ready=0 after 4. Release -> FIFO order preserved.
- FFT_RING_FAIR_INJ_EN with MAX_WAIT=8: continuous forwarded MDEST traffic plus one inject -> after 8 blocked cycles, one cycle with ring_in_ready=0 and the inject on ring_out; no ring message lost.
